wb_commit: RTL
==============

WB_COMMIT -- requirements
Module: wb_commit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register data width.
REQ-002 The block SHALL have parameter REG_AW, default 5, register address width.
REQ-003 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have inputs m_valid1, m_wreg1 (1), m_waddr1 (REG_AW), m_wdata1 (DATA_W), m_load1 (1), m_ldop1 (3: 0=LW,1=LB,2=LBU,3=LH,4=LHU), m_alo1 (2), describing slot-1 from MEM; only slot 1 SHALL ever carry a load.
REQ-006 The block SHALL have inputs m_valid2, m_wreg2, m_waddr2, m_wdata2, describing slot-2 from MEM, same widths as slot 1.
REQ-007 The block SHALL have inputs dc_valid (1) and dc_rdata (DATA_W), the data-cache load return.
REQ-008 The block SHALL have inputs stall_i (1) and flush_i (1) from pipeline control.
REQ-009 The block SHALL have outputs we1, waddr1, wdata1, we2, waddr2, wdata2, driving the register-file write ports.
REQ-010 The block SHALL have outputs stall_req (1), busy to upstream, and retire_cnt (32), committed-slot count.

Function
REQ-011 Pipeline register SHALL be held in v1, v2, slot fields; state SHALL be one of EMPTY, READY, WAIT_DATA, DRAIN.
REQ-012 Capture: at posedge, if state is EMPTY/READY, stall_i=0, flush_i=0, and the current slots complete this cycle (or none are held), MEM slot fields SHALL be registered; state -> READY if m_valid1|m_valid2, else EMPTY.
REQ-013 stall_i=1 SHALL hold all registered contents; held non-load slots SHALL still write exactly once, then clear their valid.
REQ-014 READY, no load in slot 1: we1 = v1&wreg1, we2 = v2&wreg2, combinationally, same cycle.
REQ-015 READY, slot-1 load, dc_valid=1: wdata1 = extracted dc_rdata, we1 and we2 asserted same cycle.
REQ-016 READY, slot-1 load, dc_valid=0: we1=we2=0, stall_req=1, state -> WAIT_DATA.
REQ-017 WAIT_DATA: stall_req=1, we1=we2=0 until dc_valid=1; that cycle both slots SHALL write, stall_req=0, state -> READY/EMPTY per capture rule.
REQ-018 Slot 2 SHALL never write in a cycle before slot 1 writes (program order); equal waddr on both slots SHALL be passed through unchanged.
REQ-019 Extraction: LW = dc_rdata; LB/LBU = byte m_alo1 (byte k = bits 8k+7:8k), sign/zero-extended; LH/LHU = halfword m_alo1[1], sign/zero-extended; m_alo1[0] SHALL be ignored for halfwords.
REQ-020 flush_i=1 in EMPTY/READY SHALL clear v1,v2, force we1=we2=0 that cycle, capture nothing, state -> EMPTY.
REQ-021 flush_i=1 in WAIT_DATA SHALL clear slots, state -> DRAIN; DRAIN SHALL hold stall_req=1, write nothing, discard the next dc_valid, then -> EMPTY.
REQ-022 flush_i SHALL take priority over stall_i, capture and dc_valid in the same cycle.
REQ-023 waddr output SHALL equal the registered address whenever we is 0 or 1; wdata of a disabled port is don't-care.
REQ-024 retire_cnt SHALL increment by the number of slots (0,1,2) with valid committed this cycle (including wreg=0 slots), wrapping modulo 2^32.

Reset
REQ-025 rst=1 at posedge SHALL set state EMPTY, v1=v2=0, retire_cnt=0; while rst=1 outputs we1=we2=0, stall_req=0, waddr/wdata=0.
REQ-026 rst SHALL override flush_i, stall_i and dc_valid, including mid-WAIT_DATA/DRAIN; the pending dc_valid after reset SHALL be ignored.

Verification
REQ-027 Dual ALU: slot1 r3=0x11, slot2 r4=0x22 -> next cycle we1=we2=1, waddr 3/4, wdata 0x11/0x22, retire_cnt +2.
REQ-028 LB alo=2, dc_rdata=0x12F45678 delayed 3 cycles -> stall_req=1 for 3 cycles, then wdata1=0xFFFFFFF4, slot2 writes same cycle.
REQ-029 LHU alo=3, dc_rdata=0x8001ABCD same cycle -> wdata1=0x00008001, stall_req never 1.
REQ-030 flush_i in WAIT_DATA, dc_valid 2 cycles later -> no writes, stall_req high until discard, state EMPTY, retire_cnt unchanged.
REQ-031 Both slots waddr=7 (0xA, 0xB) -> we1=we2=1, both waddr=7, wdata 0xA/0xB passed.
REQ-032 rst asserted mid-WAIT_DATA -> next cycle all outputs 0, retire_cnt=0, later dc_valid causes no write.

Source files
------------

// File: rtl/wb_commit.sv
// Writeback/commit stage: registers the two MEM slots, merges load data
// into slot 1, and drives both register-file write ports in program order.
module wb_commit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_valid1,
  input  logic              m_wreg1,
  input  logic [REG_AW-1:0] m_waddr1,
  input  logic [DATA_W-1:0] m_wdata1,
  input  logic              m_load1,
  input  logic [2:0]        m_ldop1,
  input  logic [1:0]        m_alo1,
  input  logic              m_valid2,
  input  logic              m_wreg2,
  input  logic [REG_AW-1:0] m_waddr2,
  input  logic [DATA_W-1:0] m_wdata2,
  input  logic              dc_valid,
  input  logic [DATA_W-1:0] dc_rdata,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              we1,
  output logic [REG_AW-1:0] waddr1,
  output logic [DATA_W-1:0] wdata1,
  output logic              we2,
  output logic [REG_AW-1:0] waddr2,
  output logic [DATA_W-1:0] wdata2,
  output logic              stall_req,
  output logic [31:0]       retire_cnt
);

  typedef enum logic [1:0] {
    EMPTY,
    READY,
    WAIT_DATA,
    DRAIN
  } state_t;

  state_t            st;
  logic              v1, v2;
  logic              wreg1, wreg2;
  logic              load1;
  logic [2:0]        ldop1;
  logic [1:0]        alo1;
  logic [REG_AW-1:0] a1, a2;
  logic [DATA_W-1:0] d1, d2;

  logic [7:0]        bsel;
  logic [15:0]       hsel;
  logic [DATA_W-1:0] ldata;
  logic              held, ld_pend, done, commit, can_cap;

  always_comb begin
    bsel = dc_rdata[{alo1, 3'b000} +: 8];
    hsel = dc_rdata[{alo1[1], 4'b0000} +: 16];
    case (ldop1)
      3'd1:    ldata = {{(DATA_W-8){bsel[7]}}, bsel};
      3'd2:    ldata = {{(DATA_W-8){1'b0}}, bsel};
      3'd3:    ldata = {{(DATA_W-16){hsel[15]}}, hsel};
      3'd4:    ldata = {{(DATA_W-16){1'b0}}, hsel};
      default: ldata = dc_rdata;
    endcase
  end

  // A held group retires when it has no load or its load data is back.
  always_comb begin
    held    = (st == READY) || (st == WAIT_DATA);
    ld_pend = v1 & load1;
    done    = held & (~ld_pend | dc_valid);
    commit  = done & ~flush_i & ~rst;
    can_cap = ~stall_i & ~flush_i & ((st == EMPTY) | done);
    we1     = commit & v1 & wreg1;
    we2     = commit & v2 & wreg2;
    waddr1  = rst ? '0 : a1;
    waddr2  = rst ? '0 : a2;
    wdata1  = rst ? '0 : (ld_pend ? ldata : d1);
    wdata2  = rst ? '0 : d2;
    stall_req = 1'b0;
    if (!rst) begin
      case (st)
        READY:     stall_req = ld_pend & ~dc_valid & ~flush_i;
        WAIT_DATA: stall_req = ~dc_valid | flush_i;
        DRAIN:     stall_req = 1'b1;
        default:   stall_req = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= EMPTY;
      v1         <= 1'b0;
      v2         <= 1'b0;
      wreg1      <= 1'b0;
      wreg2      <= 1'b0;
      load1      <= 1'b0;
      ldop1      <= '0;
      alo1       <= '0;
      a1         <= '0;
      a2         <= '0;
      d1         <= '0;
      d2         <= '0;
      retire_cnt <= '0;
    end else begin
      if (commit)
        retire_cnt <= retire_cnt + {31'b0, v1} + {31'b0, v2};
      if (flush_i) begin
        v1 <= 1'b0;
        v2 <= 1'b0;
        // An outstanding load return must still be swallowed.
        st <= ((st == WAIT_DATA || st == DRAIN) && !dc_valid)
              ? DRAIN : EMPTY;
      end else if (st == DRAIN) begin
        if (dc_valid) st <= EMPTY;
      end else if (can_cap) begin
        v1    <= m_valid1;
        v2    <= m_valid2;
        wreg1 <= m_wreg1;
        wreg2 <= m_wreg2;
        load1 <= m_load1;
        ldop1 <= m_ldop1;
        alo1  <= m_alo1;
        a1    <= m_waddr1;
        a2    <= m_waddr2;
        d1    <= m_wdata1;
        d2    <= m_wdata2;
        st    <= (m_valid1 | m_valid2) ? READY : EMPTY;
      end else if (done) begin
        v1 <= 1'b0;
        v2 <= 1'b0;
        st <= EMPTY;
      end else if (st == READY && ld_pend) begin
        st <= WAIT_DATA;
      end
    end
  end

endmodule
